// File: rtl/ads131_spi_pkg.sv
// Package: ads131_spi_pkg
// Purpose: Shared constants and helpers for the ADS131A0x SPI frame engine
//          and its parent sequencer.
// Contents:
//   CMD_*          16-bit device command opcodes
//   RSP_READY      16-bit status word the device sends once it is ready
//   clog2()        ceiling log2, minimum result 1, usable in constant expressions
//   left_justify() places a 16-bit opcode in the top bits of a WORD_BITS word
package ads131_spi_pkg;

    localparam logic [15:0] CMD_NULL       = 16'h0000;
    localparam logic [15:0] CMD_UNLOCK     = 16'h0655;
    localparam logic [15:0] CMD_LOCK       = 16'h0555;
    localparam logic [15:0] CMD_WAKEUP     = 16'h0033;
    localparam logic [15:0] CMD_WREG_ENALL = 16'h4F0F;
    localparam logic [15:0] RSP_READY      = 16'hFF04;

    localparam int MAX_WORD_BITS = 32;

    // Ceiling log2; never returns 0 so a counter always has at least one bit.
    function automatic int clog2(input int value);
        int result;
        result = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    // 16-bit opcodes occupy the MSBs of a device word; the low bits are zero
    // padding. Callers take the low word_bits bits of the result.
    function automatic logic [MAX_WORD_BITS-1:0] left_justify(input logic [15:0] word16,
                                                              input int          word_bits);
        logic [MAX_WORD_BITS-1:0] wide;
        wide = {16'h0000, word16};
        return wide << (word_bits - 16);
    endfunction

endpackage

// File: rtl/ads131_spi_bit_counter.sv
// Module: ads131_spi_bit_counter
// Purpose: Edge counter for one SPI frame. Counts 0..EDGES-1 on each SCLK
//          rising edge while cs_n is low, then wraps straight to 0 so frames
//          can run back to back.
// Ports:
//   SPI_SCLK_Temp  in   serial clock, all logic on posedge
//   reset_n        in   synchronous active-low reset
//   cs_n           in   chip select; high holds the counter at 0
//   bit_index      out  current edge number within the frame
//   frame_start    out  bit_index is 0 (next edge is the first of a frame)
//   frame_last     out  next edge completes the frame
//   abort_edge     out  next edge truncates a frame in progress
module ads131_spi_bit_counter #(
    parameter int EDGES    = 121,
    parameter int IDX_BITS = 7
) (
    input  logic                SPI_SCLK_Temp,
    input  logic                reset_n,
    input  logic                cs_n,
    output logic [IDX_BITS-1:0] bit_index,
    output logic                frame_start,
    output logic                frame_last,
    output logic                abort_edge
);

    // EDGES need not be a power of two, so the wrap is an explicit compare.
    localparam logic [IDX_BITS-1:0] LAST_INDEX = IDX_BITS'(EDGES - 1);

    assign frame_start = (bit_index == '0);
    assign frame_last  = !cs_n && (bit_index == LAST_INDEX);
    assign abort_edge  = cs_n && !frame_start;

    always_ff @(posedge SPI_SCLK_Temp) begin
        if (!reset_n) begin
            bit_index <= '0;
        end else if (cs_n || (bit_index == LAST_INDEX)) begin
            bit_index <= '0;
        end else begin
            bit_index <= bit_index + IDX_BITS'(1);
        end
    end

endmodule

// File: rtl/ads131_spi_frame_engine.sv
// Module: ads131_spi_frame_engine
// Purpose: SPI frame shifter for the ADS131A0x, clocked by the generated SCLK.
//          Each frame shifts tx_cmd out on MOSI (remaining words zero) and
//          captures NUM_WORDS response words from MISO. The last complete
//          frame, a frame counter, a completion toggle and a masked status
//          compare are held for the parent sequencer, which owns CS and SCLK.
// Ports:
//   SPI_SCLK_Temp   in   serial clock, all logic on posedge
//   reset_n         in   synchronous active-low reset
//   cs_n            in   chip select from the parent
//   spi_miso        in   ADC data out
//   spi_mosi        out  ADC data in
//   tx_cmd          in   command word, stable from CS fall to bit_index 1
//   expect_word     in   expected status word
//   expect_mask     in   compare mask, 1 = bit compared
//   rx_frame        out  last complete frame, word 0 at the MSBs
//   rx_status       out  word 0 of rx_frame
//   frame_count     out  completed frames, wraps
//   frame_done_tgl  out  toggles once per completed frame
//   resp_match      out  masked compare of rx_status against expect_word
//   aborted         out  last frame was cut short by cs_n
//   bit_index       out  current edge number (debug)
module ads131_spi_frame_engine
    import ads131_spi_pkg::*;
#(
    parameter int WORD_BITS = 24,
    parameter int NUM_WORDS = 5,
    parameter int CPHA      = 1,
    parameter int CNT_BITS  = 8
) (
    input  logic                                       SPI_SCLK_Temp,
    input  logic                                       reset_n,
    input  logic                                       cs_n,
    input  logic                                       spi_miso,
    output logic                                       spi_mosi,
    input  logic [WORD_BITS-1:0]                       tx_cmd,
    input  logic [WORD_BITS-1:0]                       expect_word,
    input  logic [WORD_BITS-1:0]                       expect_mask,
    output logic [NUM_WORDS*WORD_BITS-1:0]             rx_frame,
    output logic [WORD_BITS-1:0]                       rx_status,
    output logic [CNT_BITS-1:0]                        frame_count,
    output logic                                       frame_done_tgl,
    output logic                                       resp_match,
    output logic                                       aborted,
    output logic [clog2(WORD_BITS*NUM_WORDS+CPHA)-1:0] bit_index
);

    localparam int TOTAL    = WORD_BITS * NUM_WORDS;
    localparam int EDGES    = TOTAL + CPHA;
    localparam int IDX_BITS = clog2(EDGES);

    logic                 frame_start;
    logic                 frame_last;
    logic                 abort_edge;
    logic [WORD_BITS-1:0] tx_shift;
    logic                 mosi_q;
    logic [TOTAL-2:0]     rx_shift;
    logic [TOTAL-1:0]     frame_next;
    logic [WORD_BITS-1:0] word0_next;
    logic                 sample_en;

    ads131_spi_bit_counter #(
        .EDGES    (EDGES),
        .IDX_BITS (IDX_BITS)
    ) u_bit_counter (
        .SPI_SCLK_Temp (SPI_SCLK_Temp),
        .reset_n       (reset_n),
        .cs_n          (cs_n),
        .bit_index     (bit_index),
        .frame_start   (frame_start),
        .frame_last    (frame_last),
        .abort_edge    (abort_edge)
    );

    // The final MISO bit goes straight into rx_frame without passing through
    // rx_shift, so rx_shift only needs TOTAL-1 bits.
    assign frame_next = {rx_shift, spi_miso};
    assign word0_next = frame_next[TOTAL-1 -: WORD_BITS];

    // With CPHA=1 the bit on MISO at edge 0 belongs to no frame bit; the
    // first real sample is one edge later.
    assign sample_en = (CPHA == 0) || !frame_start;

    // CPHA=0 must present bit 0 before any edge, so the MSB of tx_cmd is
    // driven combinationally while the counter sits at 0.
    assign spi_mosi = (CPHA != 0) ? mosi_q
                                  : (frame_start ? tx_cmd[WORD_BITS-1] : tx_shift[WORD_BITS-1]);

    assign rx_status = rx_frame[TOTAL-1 -: WORD_BITS];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values and the block order does not matter.
    always_ff @(posedge SPI_SCLK_Temp) begin
        if (!reset_n) begin
            tx_shift       <= '0;
            mosi_q         <= 1'b0;
            rx_shift       <= '0;
            // NOTE: rx_frame is a wide register, not a RAM, and the parent may
            // read it before any frame completes, so it is reset with the rest.
            rx_frame       <= '0;
            frame_count    <= '0;
            frame_done_tgl <= 1'b0;
            resp_match     <= 1'b0;
            aborted        <= 1'b0;
        end else if (cs_n) begin
            tx_shift <= '0;
            mosi_q   <= 1'b0;
            rx_shift <= '0;
            if (abort_edge) begin
                aborted <= 1'b1;
            end
        end else begin
            // Only word 0 carries the command; shifting zeros in behind it
            // makes every later MOSI bit, and the CPHA=1 flush edge, zero.
            if (frame_start) begin
                tx_shift <= tx_cmd << 1;
                mosi_q   <= tx_cmd[WORD_BITS-1];
            end else begin
                tx_shift <= tx_shift << 1;
                mosi_q   <= tx_shift[WORD_BITS-1];
            end

            if (frame_last) begin
                rx_frame       <= frame_next;
                rx_shift       <= '0;
                frame_count    <= frame_count + CNT_BITS'(1);
                frame_done_tgl <= ~frame_done_tgl;
                aborted        <= 1'b0;
                resp_match     <= ((word0_next ^ expect_word) & expect_mask) == '0;
            end else if (sample_en) begin
                rx_shift <= frame_next[TOTAL-2:0];
            end
        end
    end

endmodule
